// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, inst} buffer between fetch and decode.
// DEPTH entries (power of two, >= 2), valid/ready on both sides, single-cycle flush.
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, an incoming
// fetch is presented to decode in the same cycle (0-cycle latency).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [`XLEN-1:0]     in_pc_i,
  input  logic [`INST_LEN-1:0] in_inst_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [`XLEN-1:0]     out_pc_o,
  output logic [`INST_LEN-1:0] out_inst_o,
  output logic [CNT_W-1:0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [`XLEN-1:0]     pc_q   [DEPTH];
  logic [`INST_LEN-1:0] inst_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic empty, full, byp, push, pop, wr_en, rd_en;

  // Handshake qualification and head presentation
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT_FULL);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = empty & in_valid_i & ~flush_i;
`else
    byp = 1'b0;
`endif
    in_ready_o  = ~full & ~flush_i;
    out_valid_o = (~empty & ~flush_i) | byp;
    out_pc_o    = byp ? in_pc_i   : pc_q[rd_ptr_q];
    out_inst_o  = byp ? in_inst_i : inst_q[rd_ptr_q];
    count_o     = count_q;
    push = in_valid_i & in_ready_o & ~flush_i;
    pop  = out_valid_o & out_ready_i & ~flush_i;
    // A bypassed entry consumed in the same cycle never touches storage or pointers.
    wr_en = push & ~(byp & out_ready_i);
    rd_en = pop & ~byp;
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_en && !rd_en)      count_d = count_q + CNT_ONE;
      else if (!wr_en && rd_en) count_d = count_q - CNT_ONE;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared only by reset, never by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (wr_en) begin
      pc_q[wr_ptr_q]   <= in_pc_i;
      inst_q[wr_ptr_q] <= in_inst_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH=4), one task per scenario plus a
// randomized scoreboard run. Honors FETCH_QUEUE_BYPASS_EN when defined.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_pc_i = '0;
  logic [31:0] in_inst_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic [2:0]  count_o;

  int vectors = 0;
  int miscompares = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_inst_o(out_inst_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven here, checks follow #1 later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    in_valid_i = 0; out_ready_i = 0; flush_i = 0;
    rst_n = 0;
    #2;
    rst_n = 1;
    tick();
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid_i = 1; in_pc_i = base + 32'(4 * i); in_inst_i = 32'(i + 1);
      tick();
    end
    in_valid_i = 0;
  endtask

  task automatic test_reset;
    clear_q();
    push_n(3, 32'h8000_0100);
    #1;
    vectors++;
    if (count_o !== 3'd3) begin miscompares++; $display("FAIL reset_precount: got %0d want 3", count_o); end
    #2;
    rst_n = 0;
    #1;
    vectors++;
    if (count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count_o); end
    vectors++;
    if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    vectors++;
    if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    vectors++;
    if (out_pc_o !== 32'h0 || out_inst_o !== 32'h0) begin
      miscompares++; $display("FAIL reset_head: got %h/%h want 0/0", out_pc_o, out_inst_o);
    end
    tick();
    rst_n = 1;
    tick();
    in_valid_i = 1; in_pc_i = 32'h8000_0000; in_inst_i = 32'h0000_0413;
    tick();
    in_valid_i = 0;
    #1;
    vectors++;
    if (out_valid_o !== 1'b1 || out_pc_o !== 32'h8000_0000 || out_inst_o !== 32'h0000_0413) begin
      miscompares++; $display("FAIL reset_first_push: got v=%b %h/%h want v=1 80000000/00000413", out_valid_o, out_pc_o, out_inst_o);
    end
    vectors++;
    if (count_o !== 3'd1) begin miscompares++; $display("FAIL reset_first_count: got %0d want 1", count_o); end
  endtask

  task automatic test_fill;
    clear_q();
    out_ready_i = 0;
    push_n(4, 32'h8000_0000);
    in_valid_i = 1; in_pc_i = 32'h8000_0010; in_inst_i = 32'h5;
    #1;
    vectors++;
    if (count_o !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d want 4", count_o); end
    vectors++;
    if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL fill_in_ready: got %b want 0", in_ready_o); end
    tick();
    vectors++;
    if (count_o !== 3'd4 || out_pc_o !== 32'h8000_0000) begin
      miscompares++; $display("FAIL fill_hold: got cnt=%0d pc=%h want cnt=4 pc=80000000", count_o, out_pc_o);
    end
    out_ready_i = 1;
    tick();
    out_ready_i = 0; in_valid_i = 0;
    #1;
    vectors++;
    if (count_o !== 3'd3) begin miscompares++; $display("FAIL fill_pop_count: got %0d want 3", count_o); end
    vectors++;
    if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL fill_pop_ready: got %b want 1", in_ready_o); end
    vectors++;
    if (out_pc_o !== 32'h8000_0004) begin miscompares++; $display("FAIL fill_pop_head: got %h want 80000004", out_pc_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] base;
    base = 32'h8000_1000;
    clear_q();
    push_n(2, base);
    out_ready_i = 1;
    for (int k = 0; k < 10; k++) begin
      in_valid_i = 1; in_pc_i = base + 32'(4 * (k + 2)); in_inst_i = 32'(k + 3);
      #1;
      vectors++;
      if (out_pc_o !== base + 32'(4 * k) || out_inst_o !== 32'(k + 1)) begin
        miscompares++; $display("FAIL b2b_order[%0d]: got %h/%h want %h/%h", k, out_pc_o, out_inst_o, base + 32'(4 * k), 32'(k + 1));
      end
      vectors++;
      if (count_o !== 3'd2) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d want 2", k, count_o); end
      tick();
    end
    in_valid_i = 0; out_ready_i = 0;
  endtask

  task automatic test_flush;
    clear_q();
    push_n(3, 32'h8000_2000);
    in_valid_i = 1; in_pc_i = 32'h8000_2FF0; in_inst_i = 32'hDEAD_BEEF;
    out_ready_i = 1; flush_i = 1;
    #1;
    vectors++;
    if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b want 0", in_ready_o); end
    vectors++;
    if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %b want 0", out_valid_o); end
    tick();
    flush_i = 0; in_valid_i = 0; out_ready_i = 0;
    #1;
    vectors++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_after: got cnt=%0d v=%b want cnt=0 v=0", count_o, out_valid_o);
    end
    in_valid_i = 1; in_pc_i = 32'h8000_3000; in_inst_i = 32'h13;
    tick();
    in_valid_i = 0;
    #1;
    vectors++;
    if (count_o !== 3'd1 || out_pc_o !== 32'h8000_3000 || out_inst_o !== 32'h13) begin
      miscompares++; $display("FAIL flush_refill: got cnt=%0d %h/%h want cnt=1 80003000/00000013", count_o, out_pc_o, out_inst_o);
    end
  endtask

  task automatic test_empty_push;
    clear_q();
    in_valid_i = 1; in_pc_i = 32'h8000_0004; in_inst_i = 32'h0000_0013; out_ready_i = 0;
    #1;
    vectors++;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (out_valid_o !== 1'b1 || out_pc_o !== 32'h8000_0004) begin
      miscompares++; $display("FAIL empty_same_cycle: got v=%b pc=%h want v=1 pc=80000004", out_valid_o, out_pc_o);
    end
`else
    if (out_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL empty_same_cycle: got v=%b want v=0", out_valid_o);
    end
`endif
    tick();
    in_valid_i = 0;
    #1;
    vectors++;
    if (out_valid_o !== 1'b1 || out_pc_o !== 32'h8000_0004 || count_o !== 3'd1) begin
      miscompares++; $display("FAIL empty_next_cycle: got v=%b pc=%h cnt=%0d want v=1 pc=80000004 cnt=1", out_valid_o, out_pc_o, count_o);
    end
    clear_q();
    in_valid_i = 1; in_pc_i = 32'h8000_0004; in_inst_i = 32'h0000_0013; out_ready_i = 1;
    tick();
    in_valid_i = 0; out_ready_i = 0;
    #1;
    vectors++;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (count_o !== 3'd0) begin miscompares++; $display("FAIL empty_bypass_consume: got cnt=%0d want 0", count_o); end
`else
    if (count_o !== 3'd1) begin miscompares++; $display("FAIL empty_bypass_consume: got cnt=%0d want 1", count_o); end
`endif
  endtask

  task automatic test_random;
    logic [63:0] mq[$];
    logic hold, exp_ir, exp_ov, byp;
    logic [63:0] head;
    int sz;
    clear_q();
    hold = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        in_pc_i = $urandom; in_inst_i = $urandom;
        in_valid_i = ($urandom_range(0, 99) < 60);
      end
      out_ready_i = ($urandom_range(0, 99) < 60);
      flush_i = ($urandom_range(0, 99) < 5);
      #1;
      sz = mq.size();
      exp_ir = (sz != 4) && !flush_i;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = (sz == 0) && in_valid_i && !flush_i;
`else
      byp = 1'b0;
`endif
      exp_ov = ((sz != 0) && !flush_i) || byp;
      head = byp ? {in_pc_i, in_inst_i} : (sz != 0 ? mq[0] : 64'h0);
      vectors++;
      if (count_o !== 3'(sz)) begin miscompares++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, count_o, sz); end
      vectors++;
      if (in_ready_o !== exp_ir || out_valid_o !== exp_ov) begin
        miscompares++; $display("FAIL rnd_hs@%0d: got ir=%b ov=%b want ir=%b ov=%b", c, in_ready_o, out_valid_o, exp_ir, exp_ov);
      end
      if (exp_ov) begin
        vectors++;
        if ({out_pc_o, out_inst_o} !== head) begin
          miscompares++; $display("FAIL rnd_data@%0d: got %h want %h", c, {out_pc_o, out_inst_o}, head);
        end
      end
      if (flush_i) mq.delete();
      else begin
        if (exp_ov && out_ready_i && !byp) void'(mq.pop_front());
        if (in_valid_i && exp_ir && !(byp && out_ready_i)) mq.push_back({in_pc_i, in_inst_i});
      end
      hold = in_valid_i && !exp_ir && !flush_i;
      tick();
    end
    in_valid_i = 0; out_ready_i = 0; flush_i = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_flush();
    test_empty_push();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
